ddr2_port_arbiter: RTL and testbench
====================================

Name: ddr2_port_arbiter

Overview:
- Shares the single DDR2 controller local port between two requesters: video pixel prefetch (read) and host frame loading (write).
- Sits between video_pixel_gen / host logic and ddr2_controller.
- Issues fixed-length bursts and generates wrapping frame addresses for each stream.
- Read has priority, bounded by a write-starvation guard.

Parameters:
- BURST_LEN, 8, words per burst (power of two, 2..64).
- WR_MAX_WAIT, 64, cycles a pending write may wait before it is forced ahead of reads.
- FRAME_WORDS, 1600, words per frame; both address counters wrap at this value.
- AW, 24, address width.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset; synchronous, active-high.
- vid_rd_req  in  1  video requests a read burst; level.
- vid_rd_data  out  24  read pixel word.
- vid_rd_valid  out  1  vid_rd_data valid.
- vid_frame_start  in  1  pulse; resets the read address to 0 at the next burst boundary.
- host_wr_req  in  1  host holds at least BURST_LEN words ready.
- host_wr_data  in  24  write word.
- host_wr_valid  in  1  host_wr_data valid.
- host_wr_ready  out  1  arbiter accepts a host word.
- local_rd_req  out  1  to ddr2_controller.
- local_rd_ready  out  1  to ddr2_controller.
- local_rd_data  in  24  from ddr2_controller.
- local_rd_valid  in  1  from ddr2_controller.
- local_wr_req  out  1  to ddr2_controller.
- local_wr_data  out  24  to ddr2_controller.
- local_wr_valid  out  1  to ddr2_controller.
- local_wr_ready  in  1  from ddr2_controller.
- local_addr  out  AW  word address of the current burst; stable for the whole burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; rd_addr=0, wr_addr=0, beat_cnt=0, wr_wait=0.
- States and transitions:
  - IDLE: arbitrates every cycle.
  - RD and WR: one burst each; exit to GAP after BURST_LEN beats.
  - GAP: one-cycle turnaround, then IDLE.
- Arbitration in IDLE, in priority order:
  - (a) host_wr_req && wr_wait>=WR_MAX_WAIT -> WR.
  - (b) vid_rd_req -> RD.
  - (c) host_wr_req -> WR.
  - (d) otherwise stay in IDLE.
- The grant decision is registered; local_*_req asserts on the cycle the new state is entered.
- wr_wait:
  - increments (saturating) each cycle host_wr_req is high and state is not WR;
  - clears on entering WR or when host_wr_req is low.
- RD state:
  - local_rd_req=1 and local_rd_ready=1; local_addr=rd_addr.
  - A beat is counted on local_rd_valid.
  - vid_rd_data=local_rd_data and vid_rd_valid=local_rd_valid, combinational, in RD only.
  - local_rd_valid outside RD is ignored.
- WR state:
  - local_wr_req=1; local_addr=wr_addr.
  - host_wr_ready = local_wr_ready && beat_cnt<BURST_LEN.
  - local_wr_valid = host_wr_valid && beat_cnt<BURST_LEN; local_wr_data=host_wr_data.
  - A beat is counted when host_wr_valid && local_wr_ready.
  - Host stalls (valid low) extend the burst; no timeout.
- Burst completion: on the final beat, deassert req/ready on the next cycle, go to GAP, and advance the stream address.
  - Next address = addr+BURST_LEN; if the result is >= FRAME_WORDS, it becomes 0.
- vid_frame_start:
  - latched into a sticky flag;
  - applied (rd_addr=0) when entering RD, or at IDLE if no burst is active;
  - a pulse during an RD burst takes effect for the next read burst only.
- Simultaneous vid_rd_req and host_wr_req with wr_wait below the limit: read wins.
- Mid-burst request changes: deassertion of the current requester's req does not abort the burst; the arbiter completes all BURST_LEN beats.
- Reset asserted mid-burst: return to IDLE next cycle with the reset values above. The DDR2 controller is reset on the same reset.

Test Plan:
1. BURST_LEN=8, FRAME_WORDS=32, vid_rd_req held high, controller returns valid every cycle -> four bursts at addresses 0, 8, 16, 24, then 0; one GAP cycle between bursts; vid_rd_valid count = 8 per burst.
2. host_wr_req only; data 0x000001..0x000008 with valid low on beat 4 for 3 cycles -> local_wr_data sequence matches in order; burst length 11 cycles; wr_addr advances 0 -> 8.
3. Both requests asserted in the same cycle from IDLE with wr_wait=0 -> RD granted first, then WR after GAP once vid_rd_req drops.
4. WR_MAX_WAIT=16, vid_rd_req permanently high, host_wr_req high -> first WR granted at the first IDLE after wr_wait reaches 16; reads resume afterward.
5. vid_frame_start pulsed during the RD burst at address 8 -> the next read burst is at address 0, not 16.
6. rst asserted at beat 3 of a WR burst -> next cycle: state IDLE, local_wr_req=0, host_wr_ready=0, wr_addr=0, busy=0.

Source files
------------

// File: rtl/ddr2_port_arbiter.sv
// ddr2_port_arbiter
// Shares the single DDR2 controller local port between the video pixel
// prefetch stream (reads) and the host frame-loading stream (writes).
// Bursts are a fixed BURST_LEN words; each stream keeps its own address
// counter that wraps at FRAME_WORDS. Reads win arbitration unless a pending
// write has waited WR_MAX_WAIT cycles.
//
// Ports
//   clk_i, rst_i             system clock, synchronous active-high reset
//   vid_rd_req_i             video wants a read burst (level)
//   vid_rd_data_o/valid_o    read words forwarded from the controller (RD only)
//   vid_frame_start_i        pulse: restart read addressing at 0 on next burst
//   host_wr_req_i            host holds at least BURST_LEN words
//   host_wr_data_i/valid_i   host write words
//   host_wr_ready_o          arbiter accepts a host word
//   local_rd_*, local_wr_*   DDR2 controller local port
//   local_addr_o             word address of the current burst
//   busy_o                   arbiter not in IDLE
module ddr2_port_arbiter #(
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned WR_MAX_WAIT = 64,
    parameter int unsigned FRAME_WORDS = 1600,
    parameter int unsigned AW          = 24
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          vid_rd_req_i,
    output logic [23:0]   vid_rd_data_o,
    output logic          vid_rd_valid_o,
    input  logic          vid_frame_start_i,
    input  logic          host_wr_req_i,
    input  logic [23:0]   host_wr_data_i,
    input  logic          host_wr_valid_i,
    output logic          host_wr_ready_o,
    output logic          local_rd_req_o,
    output logic          local_rd_ready_o,
    input  logic [23:0]   local_rd_data_i,
    input  logic          local_rd_valid_i,
    output logic          local_wr_req_o,
    output logic [23:0]   local_wr_data_o,
    output logic          local_wr_valid_o,
    input  logic          local_wr_ready_i,
    output logic [AW-1:0] local_addr_o,
    output logic          busy_o
);

    localparam int unsigned BW = $clog2(BURST_LEN) + 1;
    localparam int unsigned WW = $clog2(WR_MAX_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StGap} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WW-1:0]   wr_wait_q, wr_wait_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            frame_rst_q, frame_rst_d;

    logic            beat_open;
    logic            last_beat;
    logic            rd_beat;
    logic            wr_beat;
    logic            wr_force;
    logic [AW:0]     rd_sum;
    logic [AW:0]     wr_sum;
    logic [AW-1:0]   rd_addr_next;
    logic [AW-1:0]   wr_addr_next;

    assign beat_open = beat_cnt_q < BW'(BURST_LEN);
    assign last_beat = beat_cnt_q == BW'(BURST_LEN - 1);
    assign rd_beat   = (state_q == StRd) && local_rd_valid_i;
    assign wr_beat   = (state_q == StWr) && host_wr_valid_i && local_wr_ready_i && beat_open;
    assign wr_force  = host_wr_req_i && (wr_wait_q >= WW'(WR_MAX_WAIT));

    // Extra MSB on the sum so the wrap compare cannot overflow.
    assign rd_sum       = {1'b0, rd_addr_q} + (AW+1)'(BURST_LEN);
    assign wr_sum       = {1'b0, wr_addr_q} + (AW+1)'(BURST_LEN);
    assign rd_addr_next = (rd_sum >= (AW+1)'(FRAME_WORDS)) ? '0 : rd_sum[AW-1:0];
    assign wr_addr_next = (wr_sum >= (AW+1)'(FRAME_WORDS)) ? '0 : wr_sum[AW-1:0];

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            wr_wait_q   <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            frame_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            wr_wait_q   <= wr_wait_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            frame_rst_q <= frame_rst_d;
        end
    end

    // Next state: IDLE arbitrates, bursts end on their final beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (wr_force)           state_d = StWr;
                else if (vid_rd_req_i)  state_d = StRd;
                else if (host_wr_req_i) state_d = StWr;
            end
            StRd:    if (rd_beat && last_beat) state_d = StGap;
            StWr:    if (wr_beat && last_beat) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Beat counting, address advance, frame restart and write-wait tracking.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        frame_rst_d = frame_rst_q | vid_frame_start_i;
        wr_wait_d   = wr_wait_q;

        if (rd_beat || wr_beat) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end
        if (rd_beat && last_beat) rd_addr_d = rd_addr_next;
        if (wr_beat && last_beat) wr_addr_d = wr_addr_next;

        // Only IDLE consumes the restart, so a pulse mid-burst affects the next burst.
        if ((state_q == StIdle) && frame_rst_d) begin
            rd_addr_d   = '0;
            frame_rst_d = 1'b0;
        end

        if (!host_wr_req_i || ((state_q != StWr) && (state_d == StWr))) begin
            wr_wait_d = '0;
        end else if ((state_q != StWr) && (wr_wait_q < WW'(WR_MAX_WAIT))) begin
            wr_wait_d = wr_wait_q + 1'b1;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        vid_rd_data_o    = '0;
        vid_rd_valid_o   = 1'b0;
        host_wr_ready_o  = 1'b0;
        local_rd_req_o   = 1'b0;
        local_rd_ready_o = 1'b0;
        local_wr_req_o   = 1'b0;
        local_wr_data_o  = '0;
        local_wr_valid_o = 1'b0;
        local_addr_o     = '0;
        busy_o           = state_q != StIdle;
        unique case (state_q)
            StRd: begin
                local_rd_req_o   = 1'b1;
                local_rd_ready_o = 1'b1;
                local_addr_o     = rd_addr_q;
                vid_rd_data_o    = local_rd_data_i;
                vid_rd_valid_o   = local_rd_valid_i;
            end
            StWr: begin
                local_wr_req_o   = 1'b1;
                local_addr_o     = wr_addr_q;
                host_wr_ready_o  = local_wr_ready_i && beat_open;
                local_wr_valid_o = host_wr_valid_i && beat_open;
                local_wr_data_o  = host_wr_data_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Testbench for ddr2_port_arbiter: BURST_LEN=8, WR_MAX_WAIT=16, FRAME_WORDS=32.
module tb_ddr2_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_rd_req;
    logic [23:0] vid_rd_data;
    logic        vid_rd_valid;
    logic        vid_frame_start;
    logic        host_wr_req;
    logic [23:0] host_wr_data;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic        local_rd_req;
    logic        local_rd_ready;
    logic [23:0] local_rd_data;
    logic        local_rd_valid;
    logic        local_wr_req;
    logic [23:0] local_wr_data;
    logic        local_wr_valid;
    logic        local_wr_ready;
    logic [23:0] local_addr;
    logic        busy;

    ddr2_port_arbiter #(
        .BURST_LEN   (8),
        .WR_MAX_WAIT (16),
        .FRAME_WORDS (32),
        .AW          (24)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .vid_rd_req_i      (vid_rd_req),
        .vid_rd_data_o     (vid_rd_data),
        .vid_rd_valid_o    (vid_rd_valid),
        .vid_frame_start_i (vid_frame_start),
        .host_wr_req_i     (host_wr_req),
        .host_wr_data_i    (host_wr_data),
        .host_wr_valid_i   (host_wr_valid),
        .host_wr_ready_o   (host_wr_ready),
        .local_rd_req_o    (local_rd_req),
        .local_rd_ready_o  (local_rd_ready),
        .local_rd_data_i   (local_rd_data),
        .local_rd_valid_i  (local_rd_valid),
        .local_wr_req_o    (local_wr_req),
        .local_wr_data_o   (local_wr_data),
        .local_wr_valid_o  (local_wr_valid),
        .local_wr_ready_i  (local_wr_ready),
        .local_addr_o      (local_addr),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        valid;
        logic [23:0] data;
        logic        e_busy;
        logic        e_wreq;
        logic        e_wvalid;
        logic [23:0] e_wdata;
        logic        e_hready;
    } wr_vec_t;

    wr_vec_t     wv [14];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          nb, gaps, leaks, bad_data, cnt, off, ng;
    logic        prev_rd, prev_wr, done;
    logic [23:0] b_addr  [5];
    int          b_beats [5];
    logic        g_wr    [8];
    int          g_cyc   [8];
    logic [23:0] g_addr  [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy && n < 40);
        check(name, busy, 0);
    endtask

    function automatic wr_vec_t mk(logic req, logic valid, logic [23:0] data, logic eb,
                                   logic ew, logic ev, logic [23:0] ed, logic eh);
        wr_vec_t v;
        v.req = req; v.valid = valid; v.data = data;
        v.e_busy = eb; v.e_wreq = ew; v.e_wvalid = ev; v.e_wdata = ed; v.e_hready = eh;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Single write burst, host stalls three cycles before word 4.
        wv[0]  = mk(1, 0, 24'h0, 0, 0, 0, 24'h0, 0);
        wv[1]  = mk(0, 1, 24'h1, 1, 1, 1, 24'h1, 1);
        wv[2]  = mk(0, 1, 24'h2, 1, 1, 1, 24'h2, 1);
        wv[3]  = mk(0, 1, 24'h3, 1, 1, 1, 24'h3, 1);
        wv[4]  = mk(0, 0, 24'h0, 1, 1, 0, 24'h0, 1);
        wv[5]  = mk(0, 0, 24'h0, 1, 1, 0, 24'h0, 1);
        wv[6]  = mk(0, 0, 24'h0, 1, 1, 0, 24'h0, 1);
        wv[7]  = mk(0, 1, 24'h4, 1, 1, 1, 24'h4, 1);
        wv[8]  = mk(0, 1, 24'h5, 1, 1, 1, 24'h5, 1);
        wv[9]  = mk(0, 1, 24'h6, 1, 1, 1, 24'h6, 1);
        wv[10] = mk(0, 1, 24'h7, 1, 1, 1, 24'h7, 1);
        wv[11] = mk(0, 1, 24'h8, 1, 1, 1, 24'h8, 1);
        wv[12] = mk(0, 0, 24'h0, 1, 0, 0, 24'h0, 0);
        wv[13] = mk(0, 0, 24'h0, 0, 0, 0, 24'h0, 0);

        // Reset, with live-looking inputs that must not leak through.
        rst = 1; vid_rd_req = 0; vid_frame_start = 0; host_wr_req = 0;
        host_wr_data = 24'h123456; host_wr_valid = 1; local_rd_data = 24'hABCDEF;
        local_rd_valid = 1; local_wr_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst vid_rd_data", vid_rd_data, 0);
        check("rst vid_rd_valid", vid_rd_valid, 0);
        check("rst host_wr_ready", host_wr_ready, 0);
        check("rst local_rd_req", local_rd_req, 0);
        check("rst local_rd_ready", local_rd_ready, 0);
        check("rst local_wr_req", local_wr_req, 0);
        check("rst local_wr_data", local_wr_data, 0);
        check("rst local_wr_valid", local_wr_valid, 0);
        check("rst local_addr", local_addr, 0);
        check("rst busy", busy, 0);
        @(negedge clk);
        rst = 0; host_wr_valid = 0;
        #1;

        // Continuous reads: bursts at 0, 8, 16, 24 then wrap to 0.
        vid_rd_req = 1;
        nb = 0; gaps = 0; leaks = 0; bad_data = 0; prev_rd = 0; done = 0;
        for (int i = 0; i < 5; i++) b_beats[i] = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            local_rd_data = 24'hC00000 | 24'(c);
            #1;
            if (local_rd_req && !prev_rd) begin
                if (nb < 5) b_addr[nb] = local_addr;
                nb++;
            end
            if (vid_rd_valid && nb >= 1 && nb <= 5) b_beats[nb-1]++;
            if (!local_rd_req && (vid_rd_valid || vid_rd_data != 0)) leaks++;
            if (local_rd_req && vid_rd_data != local_rd_data) bad_data++;
            if (busy && !local_rd_req && !local_wr_req) gaps++;
            prev_rd = local_rd_req;
            if (nb == 5 && b_beats[4] == 8) done = 1;
        end
        vid_rd_req = 0;
        check("t1 five bursts seen", done, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1 burst%0d addr", i), b_addr[i], (i == 4) ? 0 : 8 * i);
            check($sformatf("t1 burst%0d beats", i), b_beats[i], 8);
        end
        check("t1 gap cycles", gaps, 4);
        check("t1 vid leak outside RD", leaks, 0);
        check("t1 vid data passthrough", bad_data, 0);
        wait_idle("t1 idle");

        // Table-driven write burst with a host stall.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            host_wr_req   = wv[i].req;
            host_wr_valid = wv[i].valid;
            host_wr_data  = wv[i].data;
            #1;
            check($sformatf("t2 busy[%0d]", i), busy, wv[i].e_busy);
            check($sformatf("t2 local_wr_req[%0d]", i), local_wr_req, wv[i].e_wreq);
            check($sformatf("t2 local_wr_valid[%0d]", i), local_wr_valid, wv[i].e_wvalid);
            check($sformatf("t2 local_wr_data[%0d]", i), local_wr_data, wv[i].e_wdata);
            check($sformatf("t2 host_wr_ready[%0d]", i), host_wr_ready, wv[i].e_hready);
            check($sformatf("t2 local_addr[%0d]", i), local_addr, 0);
        end

        // Simultaneous requests: read first, then write; reset at write beat 3.
        @(negedge clk);
        vid_rd_req = 1; host_wr_req = 1; local_rd_valid = 1; host_wr_valid = 0;
        #1;
        check("t3 idle before grant", busy, 0);
        @(negedge clk);
        vid_rd_req = 0;
        #1;
        check("t3 rd granted", local_rd_req, 1);
        check("t3 wr not granted", local_wr_req, 0);
        check("t3 rd addr", local_addr, 8);
        cnt = vid_rd_valid;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1;
            cnt += int'(vid_rd_valid);
        end
        check("t3 rd beats", cnt, 8);
        @(negedge clk);
        #1;
        check("t3 gap busy", busy, 1);
        check("t3 gap rd_req", local_rd_req, 0);
        check("t3 gap vid_rd_valid", vid_rd_valid, 0);
        @(negedge clk);
        #1;
        check("t3 idle after gap", busy, 0);
        @(negedge clk);
        host_wr_valid = 1; host_wr_data = 24'hA1;
        #1;
        check("t3 wr granted", local_wr_req, 1);
        check("t3 wr addr", local_addr, 8);
        check("t3 wr data", local_wr_data, 24'hA1);
        @(negedge clk);
        host_wr_data = 24'hA2;
        @(negedge clk);
        host_wr_data = 24'hA3; rst = 1;
        @(negedge clk);
        rst = 0; host_wr_valid = 0;
        #1;
        check("t6 busy after rst", busy, 0);
        check("t6 wr_req after rst", local_wr_req, 0);
        check("t6 host_wr_ready after rst", host_wr_ready, 0);
        check("t6 local_addr after rst", local_addr, 0);
        @(negedge clk);
        host_wr_req = 0; host_wr_valid = 1; host_wr_data = 24'hB0;
        #1;
        check("t6 wr after rst granted", local_wr_req, 1);
        check("t6 wr_addr restarted", local_addr, 0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            host_wr_data = 24'hB0 + 24'(i);
            #1;
        end
        @(negedge clk);
        host_wr_valid = 0;
        #1;
        check("t6 gap after burst", local_wr_req, 0);
        wait_idle("t6 idle");

        // Frame restart pulsed during the burst at address 8.
        vid_rd_req = 1;
        nb = 0; off = 0; prev_rd = 0;
        for (int c = 0; c < 60 && nb < 3; c++) begin
            @(negedge clk);
            vid_frame_start = (nb == 2 && off == 2);
            #1;
            if (local_rd_req && !prev_rd) begin
                if (nb < 5) b_addr[nb] = local_addr;
                nb++;
                off = 0;
            end else begin
                off++;
            end
            prev_rd = local_rd_req;
        end
        vid_rd_req = 0; vid_frame_start = 0;
        check("t5 three bursts seen", nb, 3);
        check("t5 burst0 addr", b_addr[0], 0);
        check("t5 burst1 addr", b_addr[1], 8);
        check("t5 burst2 addr after restart", b_addr[2], 0);
        wait_idle("t5 idle");

        // Write starvation guard with reads always pending.
        @(negedge clk);
        vid_rd_req = 1; host_wr_req = 1; host_wr_valid = 1; host_wr_data = 24'hC0;
        #1;
        check("t4 idle at start", busy, 0);
        ng = 0; prev_rd = 0; prev_wr = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 22) host_wr_req = 0;
            #1;
            if ((local_rd_req && !prev_rd) || (local_wr_req && !prev_wr)) begin
                if (ng < 8) begin
                    g_wr[ng]   = local_wr_req;
                    g_cyc[ng]  = c;
                    g_addr[ng] = local_addr;
                end
                ng++;
            end
            prev_rd = local_rd_req;
            prev_wr = local_wr_req;
        end
        vid_rd_req = 0; host_wr_req = 0; host_wr_valid = 0;
        check("t4 grant count", ng, 4);
        check("t4 g0 is rd", g_wr[0], 0);
        check("t4 g0 cycle", g_cyc[0], 1);
        check("t4 g0 addr", g_addr[0], 8);
        check("t4 g1 is rd", g_wr[1], 0);
        check("t4 g1 cycle", g_cyc[1], 11);
        check("t4 g1 addr", g_addr[1], 16);
        check("t4 g2 forced wr", g_wr[2], 1);
        check("t4 g2 cycle", g_cyc[2], 21);
        check("t4 g2 addr", g_addr[2], 8);
        check("t4 g3 rd resumes", g_wr[3], 0);
        check("t4 g3 cycle", g_cyc[3], 31);
        check("t4 g3 addr", g_addr[3], 24);
        wait_idle("t4 idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
